// File: rtl/stream_mux_if.sv
// Handshake bundle for stream_mux: N-channel input side, single registered output side,
// plus the mode/select controls that steer the grant.
interface stream_mux_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
);
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS-1:0]       in_ready;
    logic                      mode;
    logic [SEL_W-1:0]          sel;
    logic [WIDTH-1:0]          out_data;
    logic [SEL_W-1:0]          out_chan;
    logic                      out_valid;
    logic                      out_ready;

    modport master (
        output in_data, in_valid, mode, sel, out_ready,
        input  in_ready, out_data, out_chan, out_valid
    );

    modport slave (
        input  in_data, in_valid, mode, sel, out_ready,
        output in_ready, out_data, out_chan, out_valid
    );
endinterface

// File: rtl/stream_mux.sv
// N:1 stream multiplexer with a single registered output slot; channel chosen either
// by an external select (manual) or by a rotating-priority round-robin search.
module stream_mux #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    stream_mux_if.slave     bus
);
    localparam int PW = SEL_W + 1;

    logic [WIDTH-1:0]    out_data_q, out_data_d;
    logic [SEL_W-1:0]    out_chan_q, out_chan_d;
    logic                out_valid_q, out_valid_d;
    logic [SEL_W-1:0]    rr_ptr_q, rr_ptr_d;

    logic                load_en;
    logic                grant_vld;
    logic [SEL_W-1:0]    grant_sel;
    logic                xfer;
    logic [CHANNELS-1:0] in_ready_c;
    logic [WIDTH-1:0]    chan_data [CHANNELS];

    always_comb begin
        for (int k = 0; k < CHANNELS; k++) begin
            chan_data[k] = bus.in_data[k*WIDTH +: WIDTH];
        end
    end

    assign load_en = !out_valid_q || bus.out_ready;

    // Grant depends only on valids, controls and state, never on data.
    always_comb begin : grant_calc
        logic [PW-1:0] idx;
        grant_vld = 1'b0;
        grant_sel = '0;
        idx       = '0;
        if (!bus.mode) begin
            if ({1'b0, bus.sel} < PW'(CHANNELS)) begin
                grant_vld = 1'b1;
                grant_sel = bus.sel;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                idx = {1'b0, rr_ptr_q} + PW'(i);
                if (idx >= PW'(CHANNELS)) begin
                    idx = idx - PW'(CHANNELS);
                end
                if (!grant_vld && bus.in_valid[idx[SEL_W-1:0]]) begin
                    grant_vld = 1'b1;
                    grant_sel = idx[SEL_W-1:0];
                end
            end
        end
    end

    assign xfer = grant_vld && load_en && bus.in_valid[grant_sel];

    always_comb begin
        in_ready_c = '0;
        if (grant_vld && load_en) begin
            in_ready_c[grant_sel] = 1'b1;
        end
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        out_valid_d = out_valid_q;
        rr_ptr_d    = rr_ptr_q;
        if (load_en) begin
            out_valid_d = xfer;
            if (xfer) begin
                out_data_d = chan_data[grant_sel];
                out_chan_d = grant_sel;
            end
        end
        // Only round-robin wins advance the pointer; manual traffic leaves it alone.
        if (xfer && bus.mode) begin
            if ({1'b0, grant_sel} == PW'(CHANNELS - 1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = grant_sel + SEL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_chan_q  <= '0;
            out_valid_q <= 1'b0;
            rr_ptr_q    <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            out_valid_q <= out_valid_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_data  = out_data_q;
    assign bus.out_chan  = out_chan_q;
    assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_stream_mux.sv
// Bench for stream_mux: reset-time ready table, directed multi-cycle scenarios, then
// randomized traffic on a 4-channel and a 3-channel instance against a reference model.
module tb_stream_mux;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    stream_mux_if #(.WIDTH(8), .CHANNELS(4), .SEL_W(2)) ifa ();
    stream_mux_if #(.WIDTH(8), .CHANNELS(3), .SEL_W(2)) ifb ();

    stream_mux #(.WIDTH(8), .CHANNELS(4), .SEL_W(2)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
    stream_mux #(.WIDTH(8), .CHANNELS(3), .SEL_W(2)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       mode;
        logic [1:0] sel;
        logic [3:0] valid;
        logic       ordy;
        logic [3:0] exp_ready;
    } vec_t;

    vec_t vecs[8];

    // Reference: grant from the rules (rotating search with modulo arithmetic).
    function automatic void model_comb(input int ch, input logic mode, input int sel,
                                       input logic [3:0] valid, input logic ordy,
                                       input logic mv, input int mrr,
                                       output logic [3:0] rdy, output int g,
                                       output logic xfer, output logic load);
        bit gv;
        gv   = 0;
        g    = 0;
        load = !mv || ordy;
        if (!mode) begin
            if (sel < ch) begin gv = 1; g = sel; end
        end else begin
            for (int i = 0; i < ch; i++) begin
                int k;
                k = (mrr + i) % ch;
                if (!gv && valid[k]) begin gv = 1; g = k; end
            end
        end
        rdy  = (gv && load) ? 4'(1 << g) : 4'd0;
        xfer = gv && load && valid[g];
    endfunction

    task automatic random_run(input int d, input int cycles);
        int ch, mrr, mc, g, sel;
        logic mv, mode, ordy, xfer, load;
        logic [7:0] md;
        logic [3:0] valid, rdy;
        logic [31:0] data;
        ch = (d == 0) ? 4 : 3;
        ifa.in_valid = '0; ifb.in_valid = '0;
        rst_n = 1'b0; #1; rst_n = 1'b1;
        mv = 0; md = 0; mc = 0; mrr = 0;
        for (int n = 0; n < cycles; n++) begin
            mode  = 1'($urandom_range(0, 1));
            sel   = $urandom_range(0, 3);
            valid = 4'($urandom) & ((d == 0) ? 4'hF : 4'h7);
            data  = $urandom;
            ordy  = ($urandom_range(0, 3) != 0);
            if (d == 0) begin
                ifa.mode = mode; ifa.sel = 2'(sel); ifa.in_valid = valid;
                ifa.in_data = data; ifa.out_ready = ordy;
            end else begin
                ifb.mode = mode; ifb.sel = 2'(sel); ifb.in_valid = valid[2:0];
                ifb.in_data = data[23:0]; ifb.out_ready = ordy;
            end
            #1;
            model_comb(ch, mode, sel, valid, ordy, mv, mrr, rdy, g, xfer, load);
            if (d == 0) begin
                chk("rnd_a_ready", 32'(ifa.in_ready), 32'(rdy));
                chk("rnd_a_valid", 32'(ifa.out_valid), 32'(mv));
                chk("rnd_a_data",  32'(ifa.out_data), 32'(md));
                chk("rnd_a_chan",  32'(ifa.out_chan), 32'(mc));
            end else begin
                chk("rnd_b_ready", 32'(ifb.in_ready), 32'(rdy));
                chk("rnd_b_valid", 32'(ifb.out_valid), 32'(mv));
                chk("rnd_b_data",  32'(ifb.out_data), 32'(md));
                chk("rnd_b_chan",  32'(ifb.out_chan), 32'(mc));
            end
            tick();
            if (xfer) begin
                md = data[g*8 +: 8];
                mc = g;
                mv = 1;
                if (mode) mrr = (g + 1) % ch;
            end else if (load) begin
                mv = 0;
            end
        end
    endtask

    logic [7:0] man_exp [4];
    int         rr_seq  [6];
    int         skip_seq[4];

    initial begin
        vecs[0] = '{1'b0, 2'd0, 4'hF, 1'b1, 4'b0001};
        vecs[1] = '{1'b0, 2'd2, 4'h0, 1'b0, 4'b0100};
        vecs[2] = '{1'b0, 2'd3, 4'hF, 1'b1, 4'b1000};
        vecs[3] = '{1'b1, 2'd0, 4'h0, 1'b1, 4'b0000};
        vecs[4] = '{1'b1, 2'd3, 4'b1010, 1'b1, 4'b0010};
        vecs[5] = '{1'b1, 2'd1, 4'b1000, 1'b0, 4'b1000};
        vecs[6] = '{1'b1, 2'd2, 4'hF, 1'b1, 4'b0001};
        vecs[7] = '{1'b1, 2'd0, 4'b0100, 1'b0, 4'b0100};
        man_exp  = '{8'h11, 8'h22, 8'h33, 8'h44};
        rr_seq   = '{0, 1, 2, 3, 0, 1};
        skip_seq = '{3, 1, 3, 1};

        rst_n = 1'b0;
        ifa.in_data = '0; ifa.in_valid = '0; ifa.mode = 1'b0; ifa.sel = '0; ifa.out_ready = 1'b0;
        ifb.in_data = '0; ifb.in_valid = '0; ifb.mode = 1'b0; ifb.sel = '0; ifb.out_ready = 1'b0;
        #2;

        // In reset: state cleared, load_en = 1, in_ready purely from controls.
        chk("rst_valid", 32'(ifa.out_valid), 32'd0);
        chk("rst_data",  32'(ifa.out_data), 32'd0);
        chk("rst_chan",  32'(ifa.out_chan), 32'd0);
        for (int i = 0; i < 8; i++) begin
            ifa.mode = vecs[i].mode; ifa.sel = vecs[i].sel;
            ifa.in_valid = vecs[i].valid; ifa.out_ready = vecs[i].ordy;
            #1;
            chk($sformatf("tbl_ready_%0d", i), 32'(ifa.in_ready), 32'(vecs[i].exp_ready));
        end
        ifb.mode = 1'b0; ifb.sel = 2'd3; ifb.in_valid = 3'b111;
        #1;
        chk("rst_b_illegal_ready", 32'(ifb.in_ready), 32'd0);
        @(posedge clk); #1; rst_n = 1'b1;

        // Manual pass-through
        ifa.mode = 1'b0; ifa.out_ready = 1'b1; ifa.in_data = 32'h44332211; ifa.in_valid = 4'hF;
        for (int s = 0; s < 4; s++) begin
            ifa.sel = 2'(s);
            #1;
            chk("man_ready", 32'(ifa.in_ready), 32'(1 << s));
            tick();
            chk("man_data",  32'(ifa.out_data), 32'(man_exp[s]));
            chk("man_chan",  32'(ifa.out_chan), 32'(s));
            chk("man_valid", 32'(ifa.out_valid), 32'd1);
        end

        // Round-robin fairness from a pointer still at 0
        ifa.mode = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("rr_ready", 32'(ifa.in_ready), 32'(1 << rr_seq[i]));
            tick();
            chk("rr_chan", 32'(ifa.out_chan), 32'(rr_seq[i]));
            chk("rr_data", 32'(ifa.out_data), 32'(man_exp[rr_seq[i]]));
        end

        // Skip and wrap: pointer now 2 after the grant on channel 1
        ifa.in_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("skip_ready", 32'(ifa.in_ready), 32'(1 << skip_seq[i]));
            tick();
            chk("skip_chan", 32'(ifa.out_chan), 32'(skip_seq[i]));
        end

        // Backpressure hold
        ifa.mode = 1'b0; ifa.sel = 2'd2; ifa.in_data = 32'h00A50000; ifa.in_valid = 4'hF;
        tick();
        chk("bp_load_data", 32'(ifa.out_data), 32'hA5);
        ifa.out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            ifa.sel = 2'(c); ifa.in_data = $urandom;
            #1;
            chk("bp_ready", 32'(ifa.in_ready), 32'd0);
            tick();
            chk("bp_data",  32'(ifa.out_data), 32'hA5);
            chk("bp_chan",  32'(ifa.out_chan), 32'd2);
            chk("bp_valid", 32'(ifa.out_valid), 32'd1);
        end
        ifa.out_ready = 1'b1; ifa.sel = 2'd0; ifa.in_data = 32'h0000005A;
        #1;
        chk("bp_resume_ready", 32'(ifa.in_ready), 32'b0001);
        tick();
        chk("bp_resume_data", 32'(ifa.out_data), 32'h5A);
        chk("bp_resume_chan", 32'(ifa.out_chan), 32'd0);

        // Illegal select on the 3-channel instance
        ifb.mode = 1'b0; ifb.out_ready = 1'b1; ifb.in_valid = 3'b111;
        ifb.in_data = 24'h332211; ifb.sel = 2'd1;
        tick();
        chk("ill_load_data", 32'(ifb.out_data), 32'h22);
        ifb.sel = 2'd3;
        #1;
        chk("ill_ready", 32'(ifb.in_ready), 32'd0);
        tick();
        chk("ill_valid", 32'(ifb.out_valid), 32'd0);
        chk("ill_hold_data", 32'(ifb.out_data), 32'h22);
        chk("ill_hold_chan", 32'(ifb.out_chan), 32'd1);

        // Reset mid-stall; rr pointer is 2 from the skip test
        ifa.mode = 1'b0; ifa.sel = 2'd1; ifa.in_data = 32'h00007700; ifa.in_valid = 4'hF;
        tick();
        ifa.out_ready = 1'b0;
        tick();
        chk("stall_data", 32'(ifa.out_data), 32'h77);
        #2; rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", 32'(ifa.out_valid), 32'd0);
        chk("rst_mid_data",  32'(ifa.out_data), 32'd0);
        ifa.mode = 1'b1; ifa.in_valid = 4'b0110; ifa.out_ready = 1'b1;
        @(posedge clk); #1; rst_n = 1'b1;
        #1;
        chk("post_rst_ready", 32'(ifa.in_ready), 32'b0010);
        tick();
        chk("post_rst_chan", 32'(ifa.out_chan), 32'd1);

        random_run(0, 400);
        random_run(1, 400);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
